// File: rtl/fp_adder.sv
`default_nettype none
// ============================================================================
// Module   : fp_adder
// Purpose  : Pipelined IEEE-754 binary16 adder, round-to-nearest-even, C valid
//            three clocks after operands are sampled. Define FPADD_SUBNORMAL_EN
//            for gradual underflow; otherwise subnormals flush to zero.
// Revision : 1.0 - initial release
// ============================================================================
module fp_adder (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] C
);
    localparam logic [15:0] QNAN = 16'h7E00;

    // ---------------- stage 1: unpack, order, align ----------------
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [4:0]  a_exp, b_exp;
    logic [10:0] a_sig, b_sig;

    assign a_nan = (A[14:10] == 5'h1F) && (A[9:0] != 10'd0);
    assign b_nan = (B[14:10] == 5'h1F) && (B[9:0] != 10'd0);
    assign a_inf = (A[14:10] == 5'h1F) && (A[9:0] == 10'd0);
    assign b_inf = (B[14:10] == 5'h1F) && (B[9:0] == 10'd0);

`ifdef FPADD_SUBNORMAL_EN
    assign a_zero = (A[14:0] == 15'd0);
    assign b_zero = (B[14:0] == 15'd0);
    assign a_exp  = (A[14:10] == 5'd0) ? 5'd1 : A[14:10];
    assign b_exp  = (B[14:10] == 5'd0) ? 5'd1 : B[14:10];
    assign a_sig  = {A[14:10] != 5'd0, A[9:0]};
    assign b_sig  = {B[14:10] != 5'd0, B[9:0]};
`else
    assign a_zero = (A[14:10] == 5'd0);
    assign b_zero = (B[14:10] == 5'd0);
    assign a_exp  = A[14:10];
    assign b_exp  = B[14:10];
    assign a_sig  = a_zero ? 11'd0 : {1'b1, A[9:0]};
    assign b_sig  = b_zero ? 11'd0 : {1'b1, B[9:0]};
`endif

    logic        swap;
    logic [4:0]  big_exp, sml_exp, exp_diff;
    logic [10:0] big_sig, sml_sig;
    logic [25:0] sml_wide;
    logic [13:0] sml_al;

    assign swap     = {b_exp, b_sig} > {a_exp, a_sig};
    assign big_exp  = swap ? b_exp : a_exp;
    assign sml_exp  = swap ? a_exp : b_exp;
    assign big_sig  = swap ? b_sig : a_sig;
    assign sml_sig  = swap ? a_sig : b_sig;
    assign exp_diff = big_exp - sml_exp;
    // Layout {sig[10:0], guard, round, sticky}; everything below round folds into sticky.
    assign sml_wide = {sml_sig, 15'd0} >> exp_diff;
    assign sml_al   = (exp_diff >= 5'd14) ? {13'd0, |sml_sig}
                                          : {sml_wide[25:13], |sml_wide[12:0]};

    logic        s1_spec_d;
    logic [15:0] s1_sval_d;

    always_comb begin
        s1_spec_d = 1'b1;
        s1_sval_d = QNAN;
        if (a_nan || b_nan)                     s1_sval_d = QNAN;
        else if (a_inf && b_inf && (A[15] != B[15])) s1_sval_d = QNAN;
        else if (a_inf)                         s1_sval_d = A;
        else if (b_inf)                         s1_sval_d = B;
        else if (a_zero && b_zero)              s1_sval_d = {A[15] & B[15], 15'd0};
        else                                    s1_spec_d = 1'b0;
    end

    logic        s1_sign_q, s1_sub_q, s1_spec_q;
    logic [4:0]  s1_exp_q;
    logic [13:0] s1_big_q, s1_sml_q;
    logic [15:0] s1_sval_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_sign_q <= 1'b0;
            s1_sub_q  <= 1'b0;
            s1_spec_q <= 1'b0;
            s1_exp_q  <= 5'd0;
            s1_big_q  <= 14'd0;
            s1_sml_q  <= 14'd0;
            s1_sval_q <= 16'd0;
        end else begin
            s1_sign_q <= swap ? B[15] : A[15];
            s1_sub_q  <= A[15] ^ B[15];
            s1_spec_q <= s1_spec_d;
            s1_exp_q  <= big_exp;
            s1_big_q  <= {big_sig, 3'b000};
            s1_sml_q  <= sml_al;
            s1_sval_q <= s1_sval_d;
        end
    end

    // ---------------- stage 2: add / subtract ----------------
    logic [14:0] s2_sum_d;
    assign s2_sum_d = s1_sub_q ? ({1'b0, s1_big_q} - {1'b0, s1_sml_q})
                               : ({1'b0, s1_big_q} + {1'b0, s1_sml_q});

    logic        s2_sign_q, s2_spec_q;
    logic [4:0]  s2_exp_q;
    logic [14:0] s2_sum_q;
    logic [15:0] s2_sval_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s2_sign_q <= 1'b0;
            s2_spec_q <= 1'b0;
            s2_exp_q  <= 5'd0;
            s2_sum_q  <= 15'd0;
            s2_sval_q <= 16'd0;
        end else begin
            s2_sign_q <= s1_sign_q;
            s2_spec_q <= s1_spec_q;
            s2_exp_q  <= s1_exp_q;
            s2_sum_q  <= s2_sum_d;
            s2_sval_q <= s1_sval_q;
        end
    end

    // ---------------- stage 3: normalize ----------------
    logic [3:0]        lz, shamt;
    logic signed [6:0] s3_exp_d;
    logic [13:0]       s3_man_d;
    logic              s3_spec_d;
    logic [15:0]       s3_sval_d;

    always_comb begin
        lz = 4'd14;
        for (int i = 0; i < 14; i++) begin
            if (s2_sum_q[i]) lz = 4'(13 - i);
        end
    end

    always_comb begin
        shamt = lz;
`ifdef FPADD_SUBNORMAL_EN
        // Never normalize below exponent 1; what remains is the subnormal encoding.
        if (5'(lz) >= s2_exp_q) shamt = 4'(s2_exp_q - 5'd1);
`endif
        if (s2_sum_q[14]) begin
            s3_man_d = {s2_sum_q[14:2], s2_sum_q[1] | s2_sum_q[0]};
            s3_exp_d = $signed({2'b00, s2_exp_q}) + 7'sd1;
        end else begin
            s3_man_d = s2_sum_q[13:0] << shamt;
            s3_exp_d = $signed({2'b00, s2_exp_q}) - $signed({3'b000, shamt});
        end
        s3_spec_d = s2_spec_q;
        s3_sval_d = s2_sval_q;
        if (!s2_spec_q) begin
            if (s2_sum_q == 15'd0) begin
                s3_spec_d = 1'b1;
                s3_sval_d = 16'h0000;
            end
`ifndef FPADD_SUBNORMAL_EN
            else if (s3_exp_d <= 7'sd0) begin
                s3_spec_d = 1'b1;
                s3_sval_d = {s2_sign_q, 15'd0};
            end
`endif
        end
    end

    logic              s3_sign_q, s3_spec_q;
    logic signed [6:0] s3_exp_q;
    logic [13:0]       s3_man_q;
    logic [15:0]       s3_sval_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s3_sign_q <= 1'b0;
            s3_spec_q <= 1'b0;
            s3_exp_q  <= 7'sd0;
            s3_man_q  <= 14'd0;
            s3_sval_q <= 16'd0;
        end else begin
            s3_sign_q <= s2_sign_q;
            s3_spec_q <= s3_spec_d;
            s3_exp_q  <= s3_exp_d;
            s3_man_q  <= s3_man_d;
            s3_sval_q <= s3_sval_d;
        end
    end

    // ---------------- stage 4: round and pack ----------------
    logic              rnd_up;
    logic [11:0]       rsig;
    logic signed [6:0] rexp;
    logic [4:0]        field;
    logic [15:0]       c_d;

    always_comb begin
        rnd_up = s3_man_q[2] & (s3_man_q[1] | s3_man_q[0] | s3_man_q[3]);
        rsig   = {1'b0, s3_man_q[13:3]} + {11'd0, rnd_up};
        rexp   = s3_exp_q;
        if (rsig[11]) begin
            rsig = {1'b0, rsig[11:1]};
            rexp = s3_exp_q + 7'sd1;
        end
        // A clear hidden bit means subnormal, encoded with exponent field 0.
        field = rsig[10] ? rexp[4:0] : 5'd0;
        if (s3_spec_q)              c_d = s3_sval_q;
        else if (rexp >= 7'sd31)    c_d = {s3_sign_q, 5'h1F, 10'd0};
        else                        c_d = {s3_sign_q, field, rsig[9:0]};
    end

    always_ff @(posedge clk) begin
        if (!rst) C <= 16'h0000;
        else      C <= c_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_adder.sv
`default_nettype none
// Testbench for fp_adder: fixed vectors, pipeline/reset sequences and random
// operands checked against an exact-integer reference model.
module tb_fp_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] A = 16'h0;
    logic [15:0] B = 16'h0;
    logic [15:0] C;

    fp_adder dut (.clk(clk), .rst(rst), .A(A), .B(B), .C(C));

    always #5 clk = ~clk;

    typedef struct packed { logic [15:0] a; logic [15:0] b; logic [15:0] c; } vec_t;
    typedef struct packed { logic chk; logic [15:0] a; logic [15:0] b; logic [15:0] e; int tag; } slot_t;

    localparam slot_t RST_SLOT = '{chk: 1'b1, a: 16'h0, b: 16'h0, e: 16'h0, tag: -1};

    slot_t       p0 = '0, p1 = '0, p2 = '0, pc = '0;
    logic        chk_v = 1'b0;
    logic [15:0] exp_v = 16'h0;
    int          tag_v = 0;
    int          total = 0;
    int          bad = 0;
    int          rtotal = 0;
    int          rbad = 0;
    logic        done = 1'b0;
    vec_t        tbl [18];

    // ---------------- reference model: exact sums in units of 2^-24 ----------------
    function automatic logic is_nan(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    endfunction

    function automatic logic is_inf(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] == 10'd0);
    endfunction

    function automatic logic is_zero(input logic [15:0] x);
`ifdef FPADD_SUBNORMAL_EN
        return x[14:0] == 15'd0;
`else
        return x[14:10] == 5'd0;
`endif
    endfunction

    function automatic longint mag_of(input logic [15:0] x);
        longint f;
        int     e;
        f = longint'(x[9:0]);
        e = int'(x[14:10]);
        if (e == 0) return f;
        return (f + 64'sd1024) << (e - 1);
    endfunction

    function automatic logic [15:0] encode(input logic sign, input longint mag);
        int     p, e, q;
        longint sig, rem, half;
        p = 0;
        for (int i = 0; i < 48; i++) if (mag[i]) p = i;
        e = p - 9;
`ifdef FPADD_SUBNORMAL_EN
        if (e < 1) e = 1;
`else
        if (e < 1) return {sign, 15'd0};
`endif
        q   = e - 1;
        sig = mag >>> q;
        rem = mag - (sig <<< q);
        if (q > 0) begin
            half = 64'sd1 <<< (q - 1);
            if (rem > half || (rem == half && sig[0])) sig = sig + 1;
        end
        if (sig == 64'sd2048) begin
            sig = 64'sd1024;
            e   = e + 1;
        end
        if (e >= 31) return {sign, 5'h1F, 10'd0};
        return {sign, (sig >= 64'sd1024) ? e[4:0] : 5'd0, sig[9:0]};
    endfunction

    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        longint va, vb, s;
        if (is_nan(a) || is_nan(b)) return 16'h7E00;
        if (is_inf(a) && is_inf(b) && (a[15] != b[15])) return 16'h7E00;
        if (is_inf(a)) return a;
        if (is_inf(b)) return b;
        if (is_zero(a) && is_zero(b)) return {a[15] & b[15], 15'd0};
        va = is_zero(a) ? 64'sd0 : mag_of(a);
        vb = is_zero(b) ? 64'sd0 : mag_of(b);
        if (a[15]) va = -va;
        if (b[15]) vb = -vb;
        s = va + vb;
        if (s == 64'sd0) return 16'h0000;
        return encode(s < 0, (s < 0) ? -s : s);
    endfunction

    function automatic logic [15:0] rnd_op();
        logic [15:0] x;
        x = 16'($urandom);
        case ($urandom_range(0, 9))
            0: x[14:10] = 5'h1F;
            1: x[14:10] = 5'h00;
            2: x[14:0]  = 15'd0;
            3: x[14:10] = 5'($urandom_range(27, 30));
            default: ;
        endcase
        return x;
    endfunction

    // ---------------- expected-value pipeline and checker ----------------
    always @(posedge clk) begin
        if (!rst) begin
            pc <= RST_SLOT;
            p2 <= RST_SLOT;
            p1 <= RST_SLOT;
            p0 <= RST_SLOT;
        end else begin
            pc <= p2;
            p2 <= p1;
            p1 <= p0;
            p0 <= '{chk: chk_v, a: A, b: B, e: exp_v, tag: tag_v};
        end
    end

    always @(negedge clk) begin
        if (pc.chk) begin
            total <= total + 1;
            if (C !== pc.e) begin
                bad <= bad + 1;
                $display("FAIL sum tag=%0d a=%h b=%h got=%h want=%h", pc.tag, pc.a, pc.b, C, pc.e);
            end
        end
    end

    task automatic check_reset(input int tag);
        rtotal = rtotal + 1;
        if (C !== 16'h0000) begin
            rbad = rbad + 1;
            $display("FAIL reset tag=%0d got=%h want=0000", tag, C);
        end
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [15:0] e, input int tag);
        @(negedge clk);
        A = a; B = b; exp_v = e; chk_v = 1'b1; tag_v = tag;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk_v = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        if (!done) begin
            $display("FAIL timeout: stimulus did not complete");
            $finish;
        end
    end

    initial begin
        logic [15:0] ra, rb;

        tbl[0]  = '{16'h5620, 16'h5948, 16'h5C2C};
        tbl[1]  = '{16'h5630, 16'hD590, 16'h4900};
        tbl[2]  = '{16'hD1A0, 16'h54F0, 16'h5040};
        tbl[3]  = '{16'hDC6C, 16'hD420, 16'hDD74};
        tbl[4]  = '{16'hD6E2, 16'h563E, 16'hC920};
        tbl[5]  = '{16'h56EE, 16'h5632, 16'h5A90};
        tbl[6]  = '{16'h0000, 16'h0000, 16'h0000};
        tbl[7]  = '{16'h0000, 16'hD750, 16'hD750};
        tbl[8]  = '{16'h3C00, 16'hBC00, 16'h0000};
        tbl[9]  = '{16'h8000, 16'h8000, 16'h8000};
        tbl[10] = '{16'h3C00, 16'h1000, 16'h3C00};
        tbl[11] = '{16'h3C01, 16'h1000, 16'h3C02};
        tbl[12] = '{16'h3C00, 16'h1001, 16'h3C01};
        tbl[13] = '{16'h7BFF, 16'h7BFF, 16'h7C00};
        tbl[14] = '{16'h7C00, 16'hFC00, 16'h7E00};
        tbl[15] = '{16'h7C00, 16'h4000, 16'h7C00};
        tbl[16] = '{16'h7E00, 16'h3C00, 16'h7E00};
`ifdef FPADD_SUBNORMAL_EN
        tbl[17] = '{16'h0400, 16'h8001, 16'h03FF};
`else
        tbl[17] = '{16'h0400, 16'h8001, 16'h0400};
`endif

        rst = 1'b0; A = 16'hxxxx; B = 16'hxxxx;
        repeat (3) @(negedge clk);
        check_reset(0);
        rst = 1'b1; A = 16'h0; B = 16'h0;

        for (int i = 0; i < 18; i++) issue(tbl[i].a, tbl[i].b, tbl[i].c, i);

        issue(16'h3C00, 16'h3C00, 16'h4000, 100);
        issue(16'h4000, 16'h4000, 16'h4400, 101);
        issue(16'h4200, 16'h4200, 16'h4600, 102);

        issue(16'h3C00, 16'h4000, 16'h4200, 110);
        issue(16'h4400, 16'h4400, 16'h4800, 111);
        @(negedge clk);
        rst = 1'b0; chk_v = 1'b0; A = 16'hxxxx; B = 16'hxxxx;
        @(negedge clk);
        check_reset(1);
        rst = 1'b1; A = 16'h0; B = 16'h0;
        issue(16'h3C00, 16'h3C00, 16'h4000, 120);

        for (int i = 0; i < 2000; i++) begin
            ra = rnd_op();
            case ($urandom_range(0, 3))
                0: rb = ra ^ 16'h8000 ^ 16'($urandom_range(0, 3));
                1: rb = {~ra[15], ra[14:10] - 5'($urandom_range(0, 2)), 10'($urandom)};
                default: rb = rnd_op();
            endcase
            issue(ra, rb, ref_add(ra, rb), 1000 + i);
        end

        idle(5);
        @(negedge clk);
        #1;
        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total + rtotal, bad + rbad);
        $finish;
    end

endmodule
`default_nettype wire
